// File: rtl/hazard_scoreboard.sv
// Shift-register hazard scoreboard: tracks in-flight destinations and Tnew
// through NSTAGE post-decode stages and derives decode stall and forwarding selects.
module hazard_scoreboard #(
  parameter int NSTAGE = 3,
  parameter int NSRC   = 2,
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int SW     = $clog2(NSTAGE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NSRC*AW-1:0]        d_src,
  input  logic [NSRC-1:0]           d_src_v,
  input  logic [NSRC*TW-1:0]        d_tuse,
  input  logic [AW-1:0]             d_dst,
  input  logic                      d_we,
  input  logic [TW-1:0]             d_tnew,
  input  logic                      d_md,
  input  logic                      e_busy,
  input  logic                      e_start,
  input  logic                      flush,
  output logic                      stall,
  output logic                      pc_en,
  output logic                      d_en,
  output logic                      e_clr,
  output logic [NSTAGE*NSRC*SW-1:0] fwd_sel,
  output logic [AW-1:0]             w_dst,
  output logic                      w_we
);

  typedef struct packed {
    logic [AW-1:0]      dst;
    logic               we;
    logic [TW-1:0]      tnew;
    logic [NSRC*AW-1:0] src;
    logic [NSRC-1:0]    src_v;
  } entry_t;

  entry_t          dec;
  entry_t          ent_q [1:NSTAGE];
  logic [NSRC-1:0] data_hz;
  logic            md_hz;
  logic            unused_tail;

  function automatic logic [TW-1:0] age_tnew(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic eff_match(input entry_t e, input logic [AW-1:0] a);
    return e.we && (e.dst != '0) && (e.dst == a);
  endfunction

  assign dec = '{dst: d_dst, we: d_we, tnew: d_tnew, src: d_src, src_v: d_src_v};

  // decode -> entry 1: a stalled decode instruction is replaced by a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               ent_q[1] <= '0;
    else if (flush || stall)  ent_q[1] <= '0;
    else                      ent_q[1] <= dec;
  end

  // entry k-1 -> entry k: advance regardless of stall, Tnew saturates at zero
  for (genvar k = 2; k <= NSTAGE; k++) begin : g_shift
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ent_q[k] <= '0;
      end else if (flush) begin
        ent_q[k] <= '0;
      end else begin
        ent_q[k]      <= ent_q[k-1];
        ent_q[k].tnew <= age_tnew(ent_q[k-1].tnew);
      end
    end
  end

  // Nearest-producer search: chain runs from the oldest entry toward stage s+1
  // so a younger match overrides an older one.
  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    for (genvar j = 0; j < NSRC; j++) begin : g_opnd
      logic [AW-1:0]                   src;
      logic                            src_v;
      logic [NSTAGE+1:s+1][SW-1:0]     ns;
      logic [NSTAGE+1:s+1][TW-1:0]     nt;

      if (s == 0) begin : g_dec
        assign src   = d_src[j*AW +: AW];
        assign src_v = d_src_v[j];
      end else begin : g_ent
        assign src   = ent_q[s].src[j*AW +: AW];
        assign src_v = ent_q[s].src_v[j];
      end

      assign ns[NSTAGE+1] = '0;
      assign nt[NSTAGE+1] = '0;

      for (genvar k = s + 1; k <= NSTAGE; k++) begin : g_prod
        logic hit;
        assign hit   = src_v && eff_match(ent_q[k], src);
        assign ns[k] = hit ? SW'(NSTAGE + 1 - k) : ns[k+1];
        assign nt[k] = hit ? ent_q[k].tnew : nt[k+1];
      end

      assign fwd_sel[(s*NSRC+j)*SW +: SW] =
        ((ns[s+1] != '0) && (nt[s+1] == '0)) ? ns[s+1] : '0;

      if (s == 0) begin : g_hz
        assign data_hz[j] = (ns[1] != '0) && (nt[1] > d_tuse[j*TW +: TW]);
      end
    end
  end

  assign md_hz = d_md & (e_busy | e_start);
  assign stall = (|data_hz) | md_hz;
  assign pc_en = ~stall;
  assign d_en  = ~stall;
  assign e_clr = stall;
  assign w_dst = ent_q[NSTAGE].dst;
  assign w_we  = ent_q[NSTAGE].we;

  // The last entry's sources are never consulted; nothing forwards past write-back.
  assign unused_tail = ^{ent_q[NSTAGE].src, ent_q[NSTAGE].src_v};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios with literal
// expectations, then randomized decode traffic against a behavioural model.
module tb_hazard_scoreboard;
  localparam int NSTAGE = 3;
  localparam int NSRC   = 2;
  localparam int AW     = 5;
  localparam int TW     = 2;
  localparam int SW     = $clog2(NSTAGE + 1);
  localparam int FW     = NSTAGE * NSRC * SW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NSRC*AW-1:0] d_src = '0;
  logic [NSRC-1:0]   d_src_v = '0;
  logic [NSRC*TW-1:0] d_tuse = '0;
  logic [AW-1:0]     d_dst = '0;
  logic              d_we = 1'b0;
  logic [TW-1:0]     d_tnew = '0;
  logic              d_md = 1'b0;
  logic              e_busy = 1'b0;
  logic              e_start = 1'b0;
  logic              flush = 1'b0;
  logic              stall, pc_en, d_en, e_clr, w_we;
  logic [FW-1:0]     fwd_sel;
  logic [AW-1:0]     w_dst;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  hazard_scoreboard #(.NSTAGE(NSTAGE), .NSRC(NSRC), .AW(AW), .TW(TW), .SW(SW)) dut (
    .clk(clk), .reset(reset), .d_src(d_src), .d_src_v(d_src_v), .d_tuse(d_tuse),
    .d_dst(d_dst), .d_we(d_we), .d_tnew(d_tnew), .d_md(d_md), .e_busy(e_busy),
    .e_start(e_start), .flush(flush), .stall(stall), .pc_en(pc_en), .d_en(d_en),
    .e_clr(e_clr), .fwd_sel(fwd_sel), .w_dst(w_dst), .w_we(w_we)
  );

  always #5 clk = ~clk;

  // Behavioural model: entry k (1..NSTAGE) as plain arrays
  int m_dst  [1:NSTAGE];
  bit m_we   [1:NSTAGE];
  int m_tnew [1:NSTAGE];
  int m_src  [1:NSTAGE][0:NSRC-1];
  bit m_srcv [1:NSTAGE][0:NSRC-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 1; k <= NSTAGE; k++) begin
      m_dst[k] = 0; m_we[k] = 0; m_tnew[k] = 0;
      for (int j = 0; j < NSRC; j++) begin m_src[k][j] = 0; m_srcv[k][j] = 0; end
    end
  endtask

  function automatic void model_eval(output bit e_stall, output logic [FW-1:0] e_fwd);
    bit data_hz = 0;
    e_fwd = '0;
    for (int s = 0; s < NSTAGE; s++) begin
      for (int j = 0; j < NSRC; j++) begin
        int src;
        bit v;
        int near;
        if (s == 0) begin src = int'(d_src[j*AW +: AW]); v = d_src_v[j]; end
        else begin src = m_src[s][j]; v = m_srcv[s][j]; end
        near = 0;
        if (v) begin
          for (int k = s + 1; k <= NSTAGE; k++) begin
            if (m_we[k] && m_dst[k] != 0 && m_dst[k] == src) begin near = k; break; end
          end
        end
        if (near != 0 && m_tnew[near] == 0) e_fwd[(s*NSRC+j)*SW +: SW] = SW'(NSTAGE + 1 - near);
        if (s == 0 && near != 0 && m_tnew[near] > int'(d_tuse[j*TW +: TW])) data_hz = 1;
      end
    end
    e_stall = data_hz || (d_md && (e_busy || e_start));
  endfunction

  bit            upd_stall;
  logic [FW-1:0] upd_fwd;
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else begin
        model_eval(upd_stall, upd_fwd);
        if (flush) model_clear();
        else begin
          for (int k = NSTAGE; k >= 2; k--) begin
            m_dst[k]  = m_dst[k-1];
            m_we[k]   = m_we[k-1];
            m_tnew[k] = (m_tnew[k-1] > 0) ? m_tnew[k-1] - 1 : 0;
            for (int j = 0; j < NSRC; j++) begin
              m_src[k][j] = m_src[k-1][j]; m_srcv[k][j] = m_srcv[k-1][j];
            end
          end
          if (upd_stall) begin
            m_dst[1] = 0; m_we[1] = 0; m_tnew[1] = 0;
            for (int j = 0; j < NSRC; j++) begin m_src[1][j] = 0; m_srcv[1][j] = 0; end
          end else begin
            m_dst[1] = int'(d_dst); m_we[1] = d_we; m_tnew[1] = int'(d_tnew);
            for (int j = 0; j < NSRC; j++) begin
              m_src[1][j] = int'(d_src[j*AW +: AW]); m_srcv[1][j] = d_src_v[j];
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  bit            cmp_stall;
  logic [FW-1:0] cmp_fwd;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        model_eval(cmp_stall, cmp_fwd);
        check("cyc_stall", 64'(stall), 64'(cmp_stall));
        check("cyc_pc_en", 64'(pc_en), 64'(!cmp_stall));
        check("cyc_d_en",  64'(d_en),  64'(!cmp_stall));
        check("cyc_e_clr", 64'(e_clr), 64'(cmp_stall));
        check("cyc_fwd",   64'(fwd_sel), 64'(cmp_fwd));
        check("cyc_w_we",  64'(w_we), 64'(m_we[NSTAGE]));
        check("cyc_w_dst", 64'(w_dst), 64'(m_dst[NSTAGE]));
      end
    end
  end

  function automatic int sel(input int s, input int j);
    return int'(fwd_sel[(s*NSRC+j)*SW +: SW]);
  endfunction

  bit            pm_stall;
  logic [FW-1:0] pm_fwd;
  task automatic pin_model(input string name, input int exp_stall, input int s, input int j,
                           input int exp_sel);
    model_eval(pm_stall, pm_fwd);
    check({name, "_mstall"}, 64'(pm_stall), 64'(exp_stall));
    check({name, "_msel"}, 64'(pm_fwd[(s*NSRC+j)*SW +: SW]), 64'(exp_sel));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_dec(input int dst, input int we, input int tnew,
                         input int s0, input int v0, input int u0,
                         input int s1, input int v1, input int u1);
    d_dst = AW'(dst); d_we = 1'(we); d_tnew = TW'(tnew);
    d_src = {AW'(s1), AW'(s0)};
    d_src_v = {1'(v1), 1'(v0)};
    d_tuse = {TW'(u1), TW'(u0)};
  endtask

  task automatic set_idle();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    d_md = 0; e_busy = 0; e_start = 0; flush = 0;
  endtask

  task automatic drain();
    set_idle();
    repeat (NSTAGE + 1) tick();
  endtask

  task automatic rand_inputs();
    d_dst  = AW'($urandom_range(0, 7));
    d_we   = 1'($urandom_range(0, 1));
    d_tnew = TW'($urandom_range(0, 3));
    for (int j = 0; j < NSRC; j++) begin
      d_src[j*AW +: AW]  = AW'($urandom_range(0, 7));
      d_src_v[j]         = 1'($urandom_range(0, 1));
      d_tuse[j*TW +: TW] = TW'($urandom_range(0, 3));
    end
    d_md    = ($urandom_range(0, 5) == 0);
    e_busy  = ($urandom_range(0, 3) == 0);
    e_start = ($urandom_range(0, 5) == 0);
    flush   = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    // Reset state: MDU term is the only live stall source
    d_md = 1; e_busy = 1;
    tick();
    cmp_en = 1;
    repeat (2) tick();
    settle();
    check("rst_stall_md", 64'(stall), 64'd1);
    check("rst_pc_en", 64'(pc_en), 64'd0);
    check("rst_w_we", 64'(w_we), 64'd0);
    check("rst_w_dst", 64'(w_dst), 64'd0);
    check("rst_fwd", 64'(fwd_sel), 64'd0);
    d_md = 0; e_busy = 0;
    #1;
    check("rst_stall_idle", 64'(stall), 64'd0);
    tick(); reset = 1;
    tick();

    // ALU -> ALU, consumer at decode (tuse=0): one stall then M forward
    set_dec(3, 1, 1, 0, 0, 0, 0, 0, 0);
    tick(); set_dec(0, 0, 0, 3, 1, 0, 0, 0, 0); settle();
    check("alu0_stall", 64'(stall), 64'd1);
    pin_model("alu0", 1, 0, 0, 0);
    tick(); settle();
    check("alu0_stall2", 64'(stall), 64'd0);
    check("alu0_sel", 64'(sel(0, 0)), 64'd2);
    pin_model("alu0b", 0, 0, 0, 2);
    tick(); drain();

    // ALU -> ALU, consumer in E (tuse=1): no stall, E-stage M forward
    set_dec(3, 1, 1, 0, 0, 0, 0, 0, 0);
    tick(); set_dec(0, 0, 0, 3, 1, 1, 0, 0, 0); settle();
    check("alu1_stall", 64'(stall), 64'd0);
    check("alu1_sel0", 64'(sel(0, 0)), 64'd0);
    tick(); set_idle(); settle();
    check("alu1_sel1", 64'(sel(1, 0)), 64'd2);
    pin_model("alu1", 0, 1, 0, 2);
    tick(); drain();

    // Load-use: two stall cycles, then W forward
    set_dec(5, 1, 2, 0, 0, 0, 0, 0, 0);
    tick(); set_dec(0, 0, 0, 5, 1, 0, 0, 0, 0); settle();
    check("lu_stall1", 64'(stall), 64'd1);
    check("lu_e_clr", 64'(e_clr), 64'd1);
    check("lu_pc_en", 64'(pc_en), 64'd0);
    check("lu_d_en", 64'(d_en), 64'd0);
    tick(); settle();
    check("lu_stall2", 64'(stall), 64'd1);
    tick(); settle();
    check("lu_stall3", 64'(stall), 64'd0);
    check("lu_sel", 64'(sel(0, 0)), 64'd1);
    check("lu_w_we", 64'(w_we), 64'd1);
    check("lu_w_dst", 64'(w_dst), 64'd5);
    pin_model("lu", 0, 0, 0, 1);
    tick(); drain();

    // Shadowing on operand 1: the younger ori wins over the older addu
    set_dec(4, 1, 1, 0, 0, 0, 0, 0, 0);
    tick(); set_dec(4, 1, 1, 0, 0, 0, 0, 0, 0);
    tick(); set_dec(0, 0, 0, 0, 0, 0, 4, 1, 1); settle();
    check("shd_stall", 64'(stall), 64'd0);
    check("shd_sel0", 64'(sel(0, 1)), 64'd0);
    pin_model("shd", 0, 0, 1, 0);
    tick(); set_idle(); settle();
    check("shd_sel1", 64'(sel(1, 1)), 64'd2);
    tick(); drain();

    // Register 0 never matches
    set_dec(0, 1, 2, 0, 0, 0, 0, 0, 0);
    tick(); set_dec(0, 0, 0, 0, 1, 0, 0, 0, 0); settle();
    check("r0_stall", 64'(stall), 64'd0);
    check("r0_sel", 64'(sel(0, 0)), 64'd0);
    tick(); settle();
    check("r0_stall2", 64'(stall), 64'd0);
    tick(); drain();

    // MDU busy for five cycles
    d_md = 1; e_busy = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("mdu_busy", 64'(stall), 64'd1);
      tick();
    end
    e_busy = 0; settle();
    check("mdu_release", 64'(stall), 64'd0);
    e_start = 1; #1;
    check("mdu_start", 64'(stall), 64'd1);
    tick(); drain();

    // Flush together with a pending load hazard
    set_dec(6, 1, 2, 0, 0, 0, 0, 0, 0);
    tick(); set_dec(0, 0, 0, 6, 1, 0, 0, 0, 0); flush = 1; settle();
    check("fl_stall_pre", 64'(stall), 64'd1);
    tick(); flush = 0; settle();
    check("fl_stall", 64'(stall), 64'd0);
    check("fl_w_we", 64'(w_we), 64'd0);
    tick(); set_idle(); settle();
    check("fl_w_we2", 64'(w_we), 64'd0);
    tick(); drain();

    // Asynchronous reset in the middle of a load-use stall
    set_dec(7, 1, 2, 0, 0, 0, 0, 0, 0);
    tick(); set_dec(0, 0, 0, 7, 1, 0, 0, 0, 0); settle();
    check("ar_stall_pre", 64'(stall), 64'd1);
    tick(); reset = 0; #1;
    check("ar_stall", 64'(stall), 64'd0);
    check("ar_pc_en", 64'(pc_en), 64'd1);
    check("ar_e_clr", 64'(e_clr), 64'd0);
    check("ar_w_we", 64'(w_we), 64'd0);
    check("ar_fwd", 64'(fwd_sel), 64'd0);
    tick(); reset = 1; set_idle();
    tick();

    // Randomized traffic checked by the per-cycle compare process
    for (int c = 0; c < 3000; c++) begin
      tick();
      rand_inputs();
      reset = ($urandom_range(0, 299) != 0);
    end
    tick(); reset = 1; set_idle();
    repeat (NSTAGE + 2) tick();
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
